// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised sequence detector: the BCD digit
// type and the active-low seven-segment codes (bit order gfedcba).
package seq_det_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0011000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low seven-segment decoder.
// Non-decimal codes show a dash.
module bcd_to_seg7
  import seq_det_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Decode one BCD digit into its segment pattern.
  always_comb begin
    // NOTE: assigning a default before the case means every path drives
    // seg_o, so no latch can be inferred.
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector driven from a step key and a data switch.
// Each debounced-by-edge key press shifts one synchronised switch bit into
// the history; a full-length history equal to PATTERN produces a one-cycle
// pulse and bumps a two-digit BCD match counter shown on two HEX digits.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b0111,
  parameter bit                 OVERLAP = 1'b1,
  parameter bit                 WRAP    = 1'b0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         key1,
  input  logic                         switch0,
  input  logic                         clear,
  output logic                         success_output,
  output logic [3:0]                   count_tens,
  output logic [3:0]                   count_ones,
  output logic [$clog2(PAT_LEN+1)-1:0] fill_level,
  output logic [6:0]                   DISP0,
  output logic [6:0]                   DISP1
);

  localparam int             FW        = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0]  FILL_FULL = FW'(PAT_LEN);

  // Input synchronisers and key edge detector
  logic key_meta_q, key_sync_q, key_prev_q;
  logic sw_meta_q, sw_sync_q;
  logic strobe;

  // Detector and counter state
  logic [PAT_LEN-1:0] history_q, history_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic               success_q, success_d;
  bcd_t               ones_q, ones_d, tens_q, tens_d;

  // Candidate values used when a sample is taken
  logic [PAT_LEN-1:0] hist_shift;
  logic [FW-1:0]      fill_inc;
  logic               hit;
  bcd_t               ones_inc, tens_inc;

  // Display path
  logic [6:0] seg_ones, seg_tens;
  logic [6:0] disp0_q, disp1_q;

  // Bring the asynchronous board inputs into the clock domain and keep the
  // previous synchronised key level for rising-edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      key_meta_q <= 1'b0;
      key_sync_q <= 1'b0;
      key_prev_q <= 1'b0;
      sw_meta_q  <= 1'b0;
      sw_sync_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every stage load the value its
      // predecessor held before the edge; blocking ones would collapse the
      // chain into a single flop.
      key_meta_q <= key1;
      key_sync_q <= key_meta_q;
      key_prev_q <= key_sync_q;
      sw_meta_q  <= switch0;
      sw_sync_q  <= sw_meta_q;
    end
  end

  assign strobe     = key_sync_q & ~key_prev_q;
  assign hist_shift = {history_q[PAT_LEN-2:0], sw_sync_q};
  assign fill_inc   = (fill_q == FILL_FULL) ? fill_q : fill_q + FW'(1);
  assign hit        = strobe && (hist_shift == PATTERN) && (fill_inc == FILL_FULL);

  // Two-digit BCD increment with saturate-or-wrap at 99.
  always_comb begin
    ones_inc = ones_q;
    tens_inc = tens_q;
    if (tens_q == 4'd9 && ones_q == 4'd9) begin
      if (WRAP) begin
        ones_inc = 4'd0;
        tens_inc = 4'd0;
      end
    end else if (ones_q == 4'd9) begin
      ones_inc = 4'd0;
      tens_inc = tens_q + 4'd1;
    end else begin
      ones_inc = ones_q + 4'd1;
    end
  end

  // Next-state for history, fill level, match pulse and count; clear has
  // priority over a coincident sample.
  always_comb begin
    history_d = history_q;
    fill_d    = fill_q;
    ones_d    = ones_q;
    tens_d    = tens_q;
    success_d = 1'b0;
    if (clear) begin
      history_d = '0;
      fill_d    = '0;
      ones_d    = 4'd0;
      tens_d    = 4'd0;
    end else if (strobe) begin
      history_d = hist_shift;
      fill_d    = fill_inc;
      if (hit) begin
        success_d = 1'b1;
        ones_d    = ones_inc;
        tens_d    = tens_inc;
        if (!OVERLAP) begin
          history_d = '0;
          fill_d    = '0;
        end
      end
    end
  end

  // Detector and counter state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      history_q <= '0;
      fill_q    <= '0;
      success_q <= 1'b0;
      ones_q    <= 4'd0;
      tens_q    <= 4'd0;
    end else begin
      history_q <= history_d;
      fill_q    <= fill_d;
      success_q <= success_d;
      ones_q    <= ones_d;
      tens_q    <= tens_d;
    end
  end

  bcd_to_seg7 u_seg_ones (
    .bcd_i (ones_q),
    .seg_o (seg_ones)
  );

  bcd_to_seg7 u_seg_tens (
    .bcd_i (tens_q),
    .seg_o (seg_tens)
  );

  // Register the decoded digits; a dash is shown while reset is held.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      disp0_q <= SEG_DASH;
      disp1_q <= SEG_DASH;
    end else begin
      disp0_q <= seg_ones;
      disp1_q <= seg_tens;
    end
  end

  assign success_output = success_q;
  assign count_ones     = ones_q;
  assign count_tens     = tens_q;
  assign fill_level     = fill_q;
  assign DISP0          = disp0_q;
  assign DISP1          = disp1_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param. Four detector instances with
// different pattern/overlap/wrap settings share one stimulus stream. A
// queue-of-bits reference model per instance predicts each match and the
// count it should show; a monitor pops the prediction whenever the DUT
// pulses, and state snapshots compare fill level, count and display.
module tb_seq_detector_param;

  localparam int          PL    = 4;
  localparam int          NDUT  = 4;
  // instance order in each table: {u3, u2, u1, u0}
  localparam logic [15:0] PATS  = {4'b0111, 4'b0101, 4'b0101, 4'b0111};
  localparam logic [3:0]  OVLS  = 4'b1011;
  localparam logic [3:0]  WRAPS = 4'b1010;

  localparam int OP_SAMPLE = 0;
  localparam int OP_CLEAR  = 1;
  localparam int OP_RESET  = 2;

  localparam logic [6:0] DASH = 7'b0111111;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } cnt_t;

  logic clock = 1'b0;
  logic reset, key1, switch0, clear;

  int   tests = 0;
  int   fails = 0;
  int   cur_op;
  logic cur_bit;
  bit   in_reset;
  event model_ev, chk_ev;

  always #5 clock = ~clock;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0011000;
      default: return DASH;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam logic [PL-1:0] P   = PATS[g*PL +: PL];
    localparam bit            OVL = OVLS[g];
    localparam bit            WR  = WRAPS[g];

    logic       success_output;
    logic [3:0] count_tens, count_ones;
    logic [2:0] fill_level;
    logic [6:0] DISP0, DISP1;

    seq_detector_param #(
      .PAT_LEN (PL),
      .PATTERN (P),
      .OVERLAP (OVL),
      .WRAP    (WR)
    ) u_dut (
      .clock          (clock),
      .reset          (reset),
      .key1           (key1),
      .switch0        (switch0),
      .clear          (clear),
      .success_output (success_output),
      .count_tens     (count_tens),
      .count_ones     (count_ones),
      .fill_level     (fill_level),
      .DISP0          (DISP0),
      .DISP1          (DISP1)
    );

    bit   hist[$];   // received bits, oldest first, at most PL kept
    int   cnt = 0;   // match count as a plain integer 0..99
    cnt_t exp_q[$];  // counts expected at each future pulse

    // Reference model: reacts to each issued sample, clear or reset.
    always @(model_ev) begin
      bit hit;
      if (cur_op == OP_SAMPLE) begin
        hist.push_back(cur_bit);
        if (hist.size() > PL) void'(hist.pop_front());
        hit = (hist.size() == PL);
        for (int i = 0; i < PL; i++)
          if (hit && (hist[i] != P[PL-1-i])) hit = 1'b0;
        if (hit) begin
          if (cnt == 99) cnt = WR ? 0 : 99;
          else           cnt = cnt + 1;
          exp_q.push_back(cnt_t'{tens: 4'(cnt / 10), ones: 4'(cnt % 10)});
          if (!OVL) hist.delete();
        end
      end else begin
        hist.delete();
        cnt = 0;
        if (cur_op == OP_RESET) exp_q.delete();
      end
    end

    // Monitor: every pulse must correspond to a predicted match.
    always @(negedge clock) begin
      cnt_t e;
      if (success_output === 1'b1) begin
        check($sformatf("u%0d.pulse_predicted", g), 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check($sformatf("u%0d.pulse_tens", g), 32'(count_tens), 32'(e.tens));
          check($sformatf("u%0d.pulse_ones", g), 32'(count_ones), 32'(e.ones));
        end
      end
    end

    // State snapshot against the model.
    always @(chk_ev) begin
      check($sformatf("u%0d.fill_level", g), 32'(fill_level), 32'(hist.size()));
      check($sformatf("u%0d.count_tens", g), 32'(count_tens), 32'(cnt / 10));
      check($sformatf("u%0d.count_ones", g), 32'(count_ones), 32'(cnt % 10));
      check($sformatf("u%0d.DISP0", g), 32'(DISP0), 32'(in_reset ? DASH : seg_of(cnt % 10)));
      check($sformatf("u%0d.DISP1", g), 32'(DISP1), 32'(in_reset ? DASH : seg_of(cnt / 10)));
      check($sformatf("u%0d.success_idle", g), 32'(success_output), 32'd0);
      check($sformatf("u%0d.missing_pulses", g), 32'(exp_q.size()), 32'd0);
    end
  end

  task automatic do_check();
    ->chk_ev;
    #1;
  endtask

  task automatic press(input logic b);
    switch0 = b;
    key1    = 1'b1;
    cur_op  = OP_SAMPLE;
    cur_bit = b;
    ->model_ev;
    repeat (4) @(posedge clock);
    #1 key1 = 1'b0;
    repeat (4) @(posedge clock);
    #1;
  endtask

  task automatic clear_pulse();
    clear  = 1'b1;
    cur_op = OP_CLEAR;
    ->model_ev;
    @(posedge clock);
    #1 clear = 1'b0;
    repeat (2) @(posedge clock);
    #1;
  endtask

  // Key press whose strobe lands while clear is high: the sample is lost.
  task automatic press_with_clear(input logic b);
    switch0 = b;
    key1    = 1'b1;
    clear   = 1'b1;
    cur_op  = OP_CLEAR;
    ->model_ev;
    repeat (4) @(posedge clock);
    #1;
    key1  = 1'b0;
    clear = 1'b0;
    repeat (4) @(posedge clock);
    #1;
  endtask

  // Key held for 50 clocks with a toggling switch: exactly one sample whose
  // value is not predictable, so the model records a 0 and a clear follows.
  task automatic held_press();
    key1    = 1'b1;
    cur_op  = OP_SAMPLE;
    cur_bit = 1'b0;
    ->model_ev;
    repeat (50) begin
      @(posedge clock);
      #1 switch0 = ~switch0;
    end
    key1 = 1'b0;
    repeat (4) @(posedge clock);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b0;
    key1     = 1'b0;
    switch0  = 1'b0;
    clear    = 1'b0;
    cur_op   = OP_SAMPLE;
    cur_bit  = 1'b0;
    in_reset = 1'b1;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    do_check();
    reset    = 1'b1;
    in_reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    // Default pattern 0111
    press(1'b0); press(1'b1); press(1'b1); press(1'b1);
    do_check();

    // 0101 stream: overlap vs flush
    clear_pulse();
    for (int i = 0; i < 6; i++) press(logic'(i % 2));
    do_check();

    // Held key
    clear_pulse();
    held_press();
    do_check();
    clear_pulse();

    // 100 matches: saturate and wrap
    repeat (100) begin
      press(1'b0); press(1'b1); press(1'b1); press(1'b1);
    end
    do_check();

    // Asynchronous reset in the middle of a partial sequence
    press(1'b0); press(1'b1); press(1'b1);
    @(posedge clock);
    #3;
    reset    = 1'b0;
    in_reset = 1'b1;
    cur_op   = OP_RESET;
    ->model_ev;
    repeat (2) @(posedge clock);
    #2;
    do_check();
    @(posedge clock);
    #1;
    reset    = 1'b1;
    in_reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    press(1'b1);
    do_check();

    // Random stream with occasional clears
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(19) == 0) clear_pulse();
      else                         press(logic'($urandom_range(1)));
    end
    do_check();

    // Clear coinciding with the completing sample
    clear_pulse();
    press(1'b0); press(1'b1); press(1'b1);
    press_with_clear(1'b1);
    do_check();

    repeat (4) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
